// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, funct3 codes and state type for the memory-access stage
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int BYTE_LANES = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_t;
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts a read word down to the addressed lane and sign/zero extends it
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   value = rdata;
      F3_LBU:  value = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: value = shifted;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-bus transaction, store lane steering, load extraction
module mem_access_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       store_data,
  input  logic [2:0]            funct3,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic [4:0]            rd,
  output logic                  stall,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_result,
  output logic [4:0]            out_rd,
  output logic                  out_reg_write,
  output logic                  out_misaligned,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_addr,
  output logic                  dmem_we,
  output logic [BYTE_LANES-1:0] dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rdata
);
  mem_state_t            state_q, state_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic                  is_load_q, is_load_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  req_valid_q, req_valid_d;
  logic                  we_q, we_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_result_q, out_result_d;
  logic [4:0]            out_rd_q, out_rd_d;
  logic                  out_rw_q, out_rw_d;
  logic                  out_mis_q, out_mis_d;

  logic                  is_mem, bad_f3, misaligned;
  logic [BYTE_LANES-1:0] be_new;
  logic [XLEN-1:0]       wdata_new, load_value;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .value  (load_value)
  );

  // Decode of the incoming access; only consumed while IDLE.
  always_comb begin
    is_mem     = mem_read | mem_write;
    bad_f3     = mem_write ? (funct3 >= 3'd3) : ((funct3 == 3'd3) || (funct3 >= 3'd6));
    misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << alu_result[1:0];
        wdata_new = {2{store_data[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = store_data;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    is_load_d    = is_load_q;
    rd_d         = rd_q;
    rw_d         = rw_q;
    req_valid_d  = req_valid_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    out_valid_d  = 1'b0;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_rw_d     = out_rw_q;
    out_mis_d    = out_mis_q;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && !is_mem) begin
          out_valid_d  = 1'b1;
          out_result_d = alu_result;
          out_rd_d     = rd;
          out_rw_d     = reg_write;
          out_mis_d    = 1'b0;
        end else if (in_valid) begin
          stall     = 1'b1;
          addr_d    = alu_result;
          f3_d      = funct3;
          is_load_d = mem_read;
          rd_d      = rd;
          rw_d      = reg_write;
          if (bad_f3 || misaligned) begin
            // Faulting access completes without touching the bus.
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_rd_d     = rd;
            out_rw_d     = 1'b0;
            out_mis_d    = 1'b1;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            we_d        = mem_write;
            be_d        = be_new;
            wdata_d     = mem_write ? wdata_new : '0;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          if (is_load_q) begin
            state_d = RESP;
          end else begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_result_d = addr_q;
            out_rd_d     = rd_q;
            out_rw_d     = rw_q;
            out_mis_d    = 1'b0;
          end
        end
      end
      RESP: begin
        stall = 1'b1;
        if (dmem_rsp_valid) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_result_d = load_value;
          out_rd_d     = rd_q;
          out_rw_d     = rw_q;
          out_mis_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      is_load_q    <= 1'b0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_rw_q     <= 1'b0;
      out_mis_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      is_load_q    <= is_load_d;
      rd_q         <= rd_d;
      rw_q         <= rw_d;
      req_valid_q  <= req_valid_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_rw_q     <= out_rw_d;
      out_mis_q    <= out_mis_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_rw_q;
  assign out_misaligned = out_mis_q;
  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - vector table plus scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk, rst_n, in_valid;
  logic [31:0] alu_result, store_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write, reg_write;
  logic [4:0]  rd;
  logic        stall, out_valid, out_reg_write, out_misaligned;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd), .stall(stall), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_misaligned(out_misaligned), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    int          rdy;
    int          rsp;
    logic [31:0] e_res;
    logic        chk_res;
    logic        e_rw;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        chk_wd;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[16];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_out_cyc = -1, out_pulses = 0, pushes = 0, req_seen = 0;
  int          bus_rdy = 0, bus_rsp = 0, req_wait = 0, rsp_cnt = -1;
  logic [31:0] bus_rdata = 32'h0, exp_addr = 32'h0, exp_wd = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        exp_we = 1'b0, exp_chk_wd = 1'b0, inject_rsp = 1'b0;
  logic [36:0] snap_ctl;
  logic [31:0] snap_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every out_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      exp_t e;
      out_pulses++;
      last_out_cyc = cyc;
      check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.chk_res) check("out_result", 64'(out_result), 64'(e.res));
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_reg_write", 64'(out_reg_write), 64'(e.rw));
        check("out_misaligned", 64'(out_misaligned), 64'(e.mis));
      end
    end
  end

  // Bus model: ready after bus_rdy wait cycles, response bus_rsp cycles after a load handshake.
  always @(negedge clk) begin
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = inject_rsp;
    if (!rst_n) begin
      req_wait = 0;
      rsp_cnt  = -1;
    end else begin
      if (rsp_cnt == 0) begin
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = bus_rdata;
        rsp_cnt        = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      if (dmem_req_valid) begin
        req_seen++;
        if (req_wait == 0) begin
          snap_ctl = {dmem_addr, dmem_be, dmem_we};
          snap_wd  = dmem_wdata;
        end else begin
          check("req_ctl_stable", 64'({dmem_addr, dmem_be, dmem_we}), 64'(snap_ctl));
          check("req_wdata_stable", 64'(dmem_wdata), 64'(snap_wd));
        end
        if (req_wait >= bus_rdy) begin
          dmem_req_ready = 1'b1;
          req_wait       = 0;
          check("req_addr", 64'(dmem_addr), 64'(exp_addr));
          check("req_we", 64'(dmem_we), 64'(exp_we));
          check("req_be", 64'(dmem_be), 64'(exp_be));
          if (exp_chk_wd) check("req_wdata", 64'(dmem_wdata), 64'(exp_wd));
          if (!dmem_we) rsp_cnt = bus_rsp;
        end else begin
          req_wait++;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int start, stall_cycles, pulse_base, req_base;
    logic is_mem;
    is_mem     = v.mr || v.mw;
    bus_rdy    = v.rdy;
    bus_rsp    = v.rsp;
    bus_rdata  = v.rdata;
    exp_addr   = {v.addr[31:2], 2'b00};
    exp_be     = v.e_be;
    exp_we     = v.mw;
    exp_wd     = v.e_wd;
    exp_chk_wd = v.chk_wd;
    in_valid   = 1'b1;
    alu_result = v.addr;
    store_data = v.sd;
    funct3     = v.f3;
    mem_read   = v.mr;
    mem_write  = v.mw;
    reg_write  = v.rw;
    rd         = v.rd;
    sb_q.push_back('{v.e_res, v.chk_res, v.rd, v.e_rw, v.e_mis});
    pushes++;
    start        = cyc;
    pulse_base   = out_pulses;
    req_base     = req_seen;
    stall_cycles = 0;
    #1;
    while (stall && stall_cycles < 64) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(is_mem ? v.lat : 0));
    check({tag, "_pulses"}, 64'(out_pulses - pulse_base), 64'd1);
    check({tag, "_latency"}, 64'(last_out_cyc - start), 64'(v.lat));
    check({tag, "_req_cycles"}, 64'(req_seen - req_base), 64'((is_mem && !v.e_mis) ? v.rdy + 1 : 0));
    check({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({out_valid, out_reg_write, out_misaligned, dmem_req_valid,
                              dmem_we, stall, dmem_be, out_rd}), 64'd0);
    check({tag, "_out_result"}, 64'(out_result), 64'd0);
    check({tag, "_dmem_addr"}, 64'(dmem_addr), 64'd0);
    check({tag, "_dmem_wdata"}, 64'(dmem_wdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t post;
    //            mr    mw    f3      addr           sd             rdata          rd     rw    rdy rsp e_res          chk   e_rw  e_mis e_be     e_wd           chk_wd lat
    vecs[0]  = '{1'b0, 1'b0, 3'd0,   32'h0000_1234, 32'h0,         32'h0,         5'd5,  1'b1, 0, 0, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1};
    vecs[1]  = '{1'b0, 1'b1, F3_SB,  32'h0000_0103, 32'hAABB_CCDD, 32'h0,         5'd0,  1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 1'b0, 4'b1000, 32'hDDDD_DDDD, 1'b1, 2};
    vecs[2]  = '{1'b1, 1'b0, F3_LH,  32'h0000_0202, 32'h0,         32'h8001_7FFF, 5'd7,  1'b1, 3, 1, 32'hFFFF_8001, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h0,         1'b0, 7};
    vecs[3]  = '{1'b1, 1'b0, F3_LHU, 32'h0000_0202, 32'h0,         32'h8001_7FFF, 5'd8,  1'b1, 3, 1, 32'h0000_8001, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h0,         1'b0, 7};
    vecs[4]  = '{1'b1, 1'b0, F3_LW,  32'h0000_0301, 32'h0,         32'h0,         5'd11, 1'b1, 0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, F3_LW,  32'h0000_0010, 32'h0,         32'h1234_5678, 5'd9,  1'b1, 0, 0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0,         1'b0, 3};
    vecs[6]  = '{1'b0, 1'b0, 3'd0,   32'hCAFE_F00D, 32'h0,         32'h0,         5'd10, 1'b1, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1};
    vecs[7]  = '{1'b0, 1'b1, F3_SH,  32'h0000_0006, 32'h1111_BEEF, 32'h0,         5'd0,  1'b0, 1, 0, 32'h0,         1'b0, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 1'b1, 3};
    vecs[8]  = '{1'b0, 1'b1, F3_SW,  32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         5'd0,  1'b0, 2, 0, 32'h0,         1'b0, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 4};
    vecs[9]  = '{1'b1, 1'b0, F3_LB,  32'h0000_0041, 32'h0,         32'h0000_8000, 5'd12, 1'b1, 0, 2, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 4'b0010, 32'h0,         1'b0, 5};
    vecs[10] = '{1'b1, 1'b0, F3_LBU, 32'h0000_0043, 32'h0,         32'h7F00_0000, 5'd13, 1'b1, 0, 0, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h0,         1'b0, 3};
    vecs[11] = '{1'b0, 1'b1, F3_SH,  32'h0000_0005, 32'h1234_5678, 32'h0,         5'd0,  1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 1};
    vecs[12] = '{1'b0, 1'b1, 3'd3,   32'h0000_0000, 32'h1234_5678, 32'h0,         5'd0,  1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 1};
    vecs[13] = '{1'b1, 1'b0, 3'd6,   32'h0000_0000, 32'h0,         32'h0,         5'd14, 1'b1, 0, 0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,         1'b0, 1};
    vecs[14] = '{1'b1, 1'b0, F3_LW,  32'h0000_0044, 32'h0,         32'hA5A5_0F0F, 5'd15, 1'b1, 0, 0, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0,         1'b0, 3};
    vecs[15] = '{1'b0, 1'b0, 3'd0,   32'h0000_55AA, 32'h0,         32'h0,         5'd4,  1'b0, 0, 0, 32'h0000_55AA, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b0, 1};
    post     = '{1'b0, 1'b0, 3'd0,   32'h0BAD_F00D, 32'h0,         32'h0,         5'd6,  1'b1, 0, 0, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; funct3 = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; rd = '0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Entries 5 and 6 run back to back: the LW stays on in_valid through DONE, then the ADD follows.
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a load waits in RESP.
    @(negedge clk);
    bus_rdy = 0; bus_rsp = 20; bus_rdata = 32'hFEED_FACE;
    exp_addr = 32'h80; exp_be = 4'hF; exp_we = 1'b0; exp_chk_wd = 1'b0;
    in_valid = 1'b1; alu_result = 32'h80; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = F3_LW; rd = 5'd3; reg_write = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1 check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2 inject_rsp = 1'b1;
    @(negedge clk);
    #2 inject_rsp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("late_rsp_out_valid", 64'(out_valid), 64'd0);
      check("late_rsp_stall", 64'(stall), 64'd0);
    end
    run_vec(post, "post_rst");

    check("total_pulses", 64'(out_pulses), 64'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
